// File: rtl/mms_pkg.sv
// Shared constants, types and the padding helper for the min/max selector front end.
package mms_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int GROUP_N    = 4;

    localparam logic [DATA_W_DEF-1:0] PAD_MIN = 8'hFF;
    localparam logic [DATA_W_DEF-1:0] PAD_MAX = 8'h00;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } loader_state_t;

    typedef struct packed {
        logic                                 sel;
        logic [2:0]                           cnt;
        logic [GROUP_N-1:0][DATA_W_DEF-1:0]   num;
    } group_t;

    // All-ones can never be the minimum, zero can never beat a real maximum.
    function automatic logic [DATA_W_DEF-1:0] pad_value(input logic sel);
        return sel ? PAD_MIN : PAD_MAX;
    endfunction

endpackage

// File: rtl/mms_group_loader_if.sv
// Handshake bundle: serial element stream in, assembled 4-number group out.
interface mms_group_loader_if
    import mms_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_select;
    logic              in_last;

    logic              out_valid;
    logic              out_ready;
    logic              out_select;
    logic [DATA_W-1:0] number0;
    logic [DATA_W-1:0] number1;
    logic [DATA_W-1:0] number2;
    logic [DATA_W-1:0] number3;
    logic [2:0]        out_count;

    modport slave (
        input  in_valid, in_data, in_select, in_last, out_ready,
        output in_ready, out_valid, out_select, number0, number1, number2, number3, out_count
    );

    modport master (
        output in_valid, in_data, in_select, in_last, out_ready,
        input  in_ready, out_valid, out_select, number0, number1, number2, number3, out_count
    );

endinterface

// File: rtl/mms_group_reg.sv
// Output holding register: loads a finished group, holds it until taken, then drops valid.
module mms_group_reg
    import mms_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load_i,
    input  group_t grp_i,
    input  logic   ready_i,
    output logic   valid_o,
    output group_t grp_o
);

    logic   valid_q;
    group_t grp_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            // NOTE: the data is cleared as well, because the group outputs read as zero after reset.
            grp_q   <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            grp_q   <= grp_i;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign grp_o   = grp_q;

endmodule

// File: rtl/mms_group_loader.sv
// Packs a serial number stream into padded groups of 4 for the min/max selector.
// Define MMS_LOADER_SKID_EN to turn the assembly register into a second buffer.
module mms_group_loader
    import mms_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input logic               clk,
    input logic               rst_n,
    mms_group_loader_if.slave bus
);

    loader_state_t     state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    group_t            asm_q, asm_d;
    group_t            closed_grp;
    group_t            load_grp;
    group_t            out_grp;
    logic              load;
    logic              out_valid;
    logic              in_ready_c;
    logic              accept;
    logic              close;
    logic [DATA_W-1:0] in_data;

    assign in_data = bus.in_data;

`ifdef MMS_LOADER_SKID_EN
    assign in_ready_c = (state_q == FILL);
`else
    assign in_ready_c = !out_valid;
`endif

    assign accept = bus.in_valid && in_ready_c;
    assign close  = accept && (bus.in_last || (idx_q == 2'd3));

    // Group as it would look if the element on the bus closed it now.
    always_comb begin
        closed_grp     = asm_q;
        closed_grp.sel = (idx_q == 2'd0) ? bus.in_select : asm_q.sel;
        closed_grp.cnt = {1'b0, idx_q} + 3'd1;
        for (int k = 0; k < GROUP_N; k++) begin
            if (k == int'(idx_q)) begin
                closed_grp.num[k] = in_data;
            end else if (k > int'(idx_q)) begin
                closed_grp.num[k] = pad_value(closed_grp.sel);
            end
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d  = state_q;
        idx_d    = idx_q;
        asm_d    = asm_q;
        load     = 1'b0;
        load_grp = closed_grp;

        if (accept) begin
            asm_d.num[idx_q] = in_data;
            if (idx_q == 2'd0) begin
                asm_d.sel = bus.in_select;
            end
            idx_d = idx_q + 2'd1;
        end

        if (close) begin
            idx_d = 2'd0;
`ifdef MMS_LOADER_SKID_EN
            if (!out_valid || bus.out_ready) begin
                load = 1'b1;
            end else begin
                asm_d   = closed_grp;
                state_d = FULL;
            end
`else
            load = 1'b1;
`endif
        end

`ifdef MMS_LOADER_SKID_EN
        // A parked group moves out as soon as the consumer takes the current one.
        if ((state_q == FULL) && bus.out_ready) begin
            load     = 1'b1;
            load_grp = asm_q;
            state_d  = FILL;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FILL;
            idx_q   <= 2'd0;
            asm_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
        end
    end

    mms_group_reg u_group_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load),
        .grp_i   (load_grp),
        .ready_i (bus.out_ready),
        .valid_o (out_valid),
        .grp_o   (out_grp)
    );

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = out_valid;
    assign bus.out_select = out_grp.sel;
    assign bus.out_count  = out_grp.cnt;
    assign bus.number0    = out_grp.num[0];
    assign bus.number1    = out_grp.num[1];
    assign bus.number2    = out_grp.num[2];
    assign bus.number3    = out_grp.num[3];

endmodule

// File: tb/tb_mms_group_loader.sv
// Bench for mms_group_loader: directed bursts, a queue-based reference model and literal group checks.
module tb_mms_group_loader;

    localparam int W = 8;
`ifdef MMS_LOADER_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mms_group_loader_if #(.DATA_W(W)) vi ();

    mms_group_loader #(.DATA_W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (vi.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_bound(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // ---------------- reference model: element list, closed-group queue, output slot
    typedef struct {
        logic       sel;
        logic [2:0] cnt;
        logic [7:0] num [4];
    } mgrp_t;

    mgrp_t      held[$];
    mgrp_t      m_grp;
    logic [7:0] m_elems[$];
    logic       m_sel;
    bit         m_valid    = 1'b0;
    bit         m_in_ready = 1'b0;
    bit         m_live     = 1'b0;

    initial begin : compare
        logic  acc;
        mgrp_t g;
        logic [7:0] dn [4];
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                held.delete();
                m_elems.delete();
                m_valid = 1'b0;
                m_live  = 1'b1;
            end else if (m_live) begin
                acc = vi.in_valid && m_in_ready;
                if (m_valid && vi.out_ready) m_valid = 1'b0;
                if (acc) begin
                    if (m_elems.size() == 0) m_sel = vi.in_select;
                    m_elems.push_back(vi.in_data);
                    if (vi.in_last || m_elems.size() == 4) begin
                        g.sel = m_sel;
                        g.cnt = 3'(m_elems.size());
                        for (int k = 0; k < 4; k++)
                            g.num[k] = (k < m_elems.size()) ? m_elems[k] : (m_sel ? 8'hFF : 8'h00);
                        held.push_back(g);
                        m_elems.delete();
                    end
                end
                if (!m_valid && held.size() > 0) begin
                    m_grp   = held.pop_front();
                    m_valid = 1'b1;
                end
            end
            m_in_ready = SKID ? (held.size() == 0) : !m_valid;
            if (m_live) begin
                check("cmp_out_valid", 32'(vi.out_valid), 32'(m_valid));
                check("cmp_in_ready", 32'(vi.in_ready), 32'(m_in_ready));
                if (m_valid) begin
                    dn = '{vi.number0, vi.number1, vi.number2, vi.number3};
                    check("cmp_select", 32'(vi.out_select), 32'(m_grp.sel));
                    check("cmp_count", 32'(vi.out_count), 32'(m_grp.cnt));
                    for (int k = 0; k < 4; k++)
                        check("cmp_number", 32'(dn[k]), 32'(m_grp.num[k]));
                end
            end
        end
    end

    // ---------------- handshake recorder for throughput spacing
    int cyc = 0;
    int hs_q[$];
    bit rec_en = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (rec_en && vi.out_valid && vi.out_ready) hs_q.push_back(cyc);

    // ---------------- stimulus helpers (all return on a falling edge)
    typedef struct {
        logic [7:0] data;
        logic       sel;
        logic       last;
    } elem_t;
    elem_t stim[$];

    task automatic add(input logic [7:0] d, input logic s, input logic l);
        elem_t e;
        e.data = d;
        e.sel  = s;
        e.last = l;
        stim.push_back(e);
    endtask

    task automatic run_burst(input string name);
        elem_t e;
        int    n;
        while (stim.size() > 0) begin
            e = stim.pop_front();
            vi.in_valid  = 1'b1;
            vi.in_data   = e.data;
            vi.in_select = e.sel;
            vi.in_last   = e.last;
            n = 0;
            while (!vi.in_ready && n < 40) begin
                @(negedge clk);
                n++;
            end
            if (n >= 40) begin
                fail_bound(name);
                stim.delete();
            end else begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        vi.in_valid = 1'b0;
        vi.in_last  = 1'b0;
    endtask

    task automatic expect_group(input string name, input logic [31:0] nums, input logic sel,
                                input logic [2:0] cnt, input int maxw);
        int n = 0;
        while (!vi.out_valid && n < maxw) begin
            @(negedge clk);
            n++;
        end
        check({name, "_valid"}, 32'(vi.out_valid), 32'd1);
        check({name, "_n0"}, 32'(vi.number0), 32'(nums[31:24]));
        check({name, "_n1"}, 32'(vi.number1), 32'(nums[23:16]));
        check({name, "_n2"}, 32'(vi.number2), 32'(nums[15:8]));
        check({name, "_n3"}, 32'(vi.number3), 32'(nums[7:0]));
        check({name, "_sel"}, 32'(vi.out_select), 32'(sel));
        check({name, "_cnt"}, 32'(vi.out_count), 32'(cnt));
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        rst_n        = 1'b0;
        vi.in_valid  = 1'b0;
        vi.in_data   = '0;
        vi.in_select = 1'b0;
        vi.in_last   = 1'b0;
        vi.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        check("rst_valid", 32'(vi.out_valid), 32'd0);
        check("rst_select", 32'(vi.out_select), 32'd0);
        check("rst_count", 32'(vi.out_count), 32'd0);
        check("rst_numbers", {vi.number0, vi.number1, vi.number2, vi.number3}, 32'h0);
        check("rst_in_ready", 32'(vi.in_ready), 32'd1);

        // 1: full group, one-cycle latency
        vi.out_ready = 1'b1;
        add(8'd5, 1'b1, 1'b0); add(8'd3, 1'b0, 1'b0); add(8'd9, 1'b0, 1'b0); add(8'd7, 1'b0, 1'b0);
        run_burst("t1");
        expect_group("t1", {8'd5, 8'd3, 8'd9, 8'd7}, 1'b1, 3'd4, 0);

        // 2: single-element groups, both paddings
        add(8'h20, 1'b0, 1'b1);
        run_burst("t2a");
        expect_group("t2a", 32'h20_00_00_00, 1'b0, 3'd1, 0);
        add(8'h20, 1'b1, 1'b1);
        run_burst("t2b");
        expect_group("t2b", 32'h20_FF_FF_FF, 1'b1, 3'd1, 0);

        // 3: select only sampled on the first element
        add(8'h11, 1'b1, 1'b0); add(8'h22, 1'b0, 1'b0); add(8'h33, 1'b1, 1'b0); add(8'h44, 1'b0, 1'b0);
        run_burst("t3");
        expect_group("t3", 32'h11_22_33_44, 1'b1, 3'd4, 0);

        // 4: back-pressure, hold stability
        @(negedge clk);
        vi.out_ready = 1'b0;
        add(8'hA1, 1'b0, 1'b0); add(8'hA2, 1'b0, 1'b0); add(8'hA3, 1'b0, 1'b0); add(8'hA4, 1'b0, 1'b0);
        run_burst("t4a");
        expect_group("t4a", 32'hA1_A2_A3_A4, 1'b0, 3'd4, 0);
`ifdef MMS_LOADER_SKID_EN
        add(8'hB1, 1'b1, 1'b0); add(8'hB2, 1'b0, 1'b0); add(8'hB3, 1'b0, 1'b0); add(8'hB4, 1'b0, 1'b0);
        run_burst("t4skid");
`endif
        for (int i = 0; i < 10; i++) begin
            check("t4_hold_nums", {vi.number0, vi.number1, vi.number2, vi.number3}, 32'hA1_A2_A3_A4);
            check("t4_hold_sel", 32'(vi.out_select), 32'd0);
            check("t4_hold_cnt", 32'(vi.out_count), 32'd4);
            check("t4_hold_valid", 32'(vi.out_valid), 32'd1);
            check("t4_hold_in_ready", 32'(vi.in_ready), 32'd0);
            @(negedge clk);
        end
        vi.out_ready = 1'b1;
        @(negedge clk);
`ifdef MMS_LOADER_SKID_EN
        expect_group("t4b", 32'hB1_B2_B3_B4, 1'b1, 3'd4, 0);
        @(negedge clk);
`else
        check("t4_after_valid", 32'(vi.out_valid), 32'd0);
        check("t4_after_in_ready", 32'(vi.in_ready), 32'd1);
`endif

        // 5: streaming throughput
        hs_q.delete();
        rec_en = 1'b1;
        for (int i = 0; i < (SKID ? 12 : 8); i++) add(8'(8'h40 + i), 1'b0, 1'b0);
        run_burst("t5");
        repeat (3) @(negedge clk);
        rec_en = 1'b0;
        check("t5_groups", 32'(hs_q.size()), SKID ? 32'd3 : 32'd2);
        for (int i = 1; i < hs_q.size(); i++)
            check("t5_spacing", 32'(hs_q[i] - hs_q[i-1]), SKID ? 32'd4 : 32'd5);

        // 6: reset mid-group drops the partial group
        add(8'hAA, 1'b1, 1'b0); add(8'hBB, 1'b1, 1'b0);
        run_burst("t6pre");
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t6_rst_valid", 32'(vi.out_valid), 32'd0);
        check("t6_rst_in_ready", 32'(vi.in_ready), 32'd1);
        check("t6_rst_count", 32'(vi.out_count), 32'd0);
        add(8'd1, 1'b0, 1'b0); add(8'd2, 1'b0, 1'b0); add(8'd3, 1'b0, 1'b0); add(8'd4, 1'b0, 1'b0);
        run_burst("t6");
        expect_group("t6", 32'h01_02_03_04, 1'b0, 3'd4, 0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
